// File: rtl/qam_demapper_serial.sv
// Hard-decision QPSK/16/64-QAM demapper with DC-offset calibration, symbol FIFO and LSB-first serial output.
// Sample -> first serial bit is 3 edges; en=0 stalls the serializer and symbols arriving on a full FIFO are dropped (sticky overflow).
module qam_demapper_serial #(
  parameter int IN_W       = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CAL_LOG2   = 4
) (
  input  logic                   dclk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] i_in,
  input  logic signed [IN_W-1:0] q_in,
  input  logic                   sym_valid,
  input  logic [1:0]             mode,
  input  logic                   cal_start,
  input  logic                   en,
  output logic                   data_out,
  output logic                   data_valid,
  output logic                   sym_start,
  output logic                   cal_busy,
  output logic                   overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ACC_W = IN_W + CAL_LOG2;
  localparam logic signed [IN_W-1:0] T1  = IN_W'(2 ** (IN_W - 3));
  localparam logic signed [IN_W-1:0] T2  = IN_W'(2 * (2 ** (IN_W - 3)));
  localparam logic signed [IN_W-1:0] T3  = IN_W'(3 * (2 ** (IN_W - 3)));
  localparam logic signed [IN_W-1:0] NT1 = -T1;
  localparam logic signed [IN_W-1:0] NT2 = -T2;
  localparam logic signed [IN_W-1:0] NT3 = -T3;

  typedef enum logic {RUN, CAL} state_t;
  state_t r_state, w_state_nxt;

  logic [CAL_LOG2-1:0]     r_cnt;
  logic signed [ACC_W-1:0] r_acc_i, r_acc_q, w_sum_i, w_sum_q;
  logic signed [IN_W-1:0]  r_off_i, r_off_q;
  logic                    w_cal_last;

  assign w_cal_last = (r_state == CAL) && sym_valid && (&r_cnt);
  assign w_sum_i    = r_acc_i + ACC_W'(i_in);
  assign w_sum_q    = r_acc_q + ACC_W'(q_in);
  assign cal_busy   = (r_state == CAL);

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cal_start)       w_state_nxt = CAL;
    else if (w_cal_last) w_state_nxt = RUN;
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_off_i <= '0;
      r_off_q <= '0;
    end else if (cal_start) begin
      r_cnt   <= '0;
      r_acc_i <= '0;
      r_acc_q <= '0;
    end else if (r_state == CAL && sym_valid) begin
      if (&r_cnt) begin
        r_off_i <= IN_W'(w_sum_i >>> CAL_LOG2);
        r_off_q <= IN_W'(w_sum_q >>> CAL_LOG2);
        r_acc_i <= '0;
        r_acc_q <= '0;
        r_cnt   <= '0;
      end else begin
        r_acc_i <= w_sum_i;
        r_acc_q <= w_sum_q;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  function automatic logic signed [IN_W-1:0] correct(input logic signed [IN_W-1:0] x,
                                                     input logic signed [IN_W-1:0] off);
    logic [IN_W:0] w_d;
    w_d = {x[IN_W-1], x} - {off[IN_W-1], off};
    if (w_d[IN_W] != w_d[IN_W-1])
      correct = w_d[IN_W] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
    else
      correct = w_d[IN_W-1:0];
  endfunction

  // Returns {positive, inverted-Gray amplitude}; a sample on a threshold falls to the lower region.
  function automatic logic [2:0] slice_axis(input logic signed [IN_W-1:0] c, input logic [1:0] m);
    logic       w_pos;
    logic [1:0] w_a;
    w_pos = !c[IN_W-1] && (c != '0);
    w_a   = 2'd0;
    if (m == 2'd2) begin
      if (w_pos) w_a = (c > T3) ? 2'd3 : (c > T2) ? 2'd2 : (c > T1) ? 2'd1 : 2'd0;
      else       w_a = (c <= NT3) ? 2'd3 : (c <= NT2) ? 2'd2 : (c <= NT1) ? 2'd1 : 2'd0;
    end else if (m == 2'd1) begin
      w_a = w_pos ? {1'b0, c > T2} : {1'b0, c <= NT2};
    end
    slice_axis = {w_pos, ~{w_a[1], w_a[1] ^ w_a[0]}};
  endfunction

  logic                   r_s0_vld, r_s1_vld;
  logic signed [IN_W-1:0] r_s0_i, r_s0_q, r_s1_ci, r_s1_cq;
  logic [1:0]             r_s0_mode, r_s1_mode;

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      r_s0_vld  <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s0_i    <= '0;
      r_s0_q    <= '0;
      r_s0_mode <= 2'd0;
      r_s1_ci   <= '0;
      r_s1_cq   <= '0;
      r_s1_mode <= 2'd0;
    end else if (cal_start) begin
      r_s0_vld <= 1'b0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s0_vld  <= sym_valid && (r_state == RUN);
      r_s0_i    <= i_in;
      r_s0_q    <= q_in;
      r_s0_mode <= (mode == 2'd3) ? 2'd1 : mode;
      r_s1_vld  <= r_s0_vld;
      r_s1_ci   <= correct(r_s0_i, r_off_i);
      r_s1_cq   <= correct(r_s0_q, r_off_q);
      r_s1_mode <= r_s0_mode;
    end
  end

  logic [2:0] w_si, w_sq;
  logic [5:0] w_word;
  assign w_si = slice_axis(r_s1_ci, r_s1_mode);
  assign w_sq = slice_axis(r_s1_cq, r_s1_mode);

  always_comb begin
    w_word = 6'd0;
    case (r_s1_mode)
      2'd0:    w_word = {4'b0000, w_si[2], ~w_sq[2]};
      2'd2:    w_word = {w_si[2], w_si[1:0], ~w_sq[2], w_sq[1:0]};
      default: w_word = {2'b00, w_si[2], w_si[0], ~w_sq[2], w_sq[0]};
    endcase
  end

  // Each entry holds {mode, word} so the serializer knows the word length.
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic        w_empty, w_full, w_pop, w_push;
  logic [7:0]  w_rd;
  logic [2:0]  r_left, w_last_idx;
  logic [4:0]  r_sh;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = en && (r_left == 3'd0) && !w_empty;
  assign w_push  = r_s1_vld && (!w_full || w_pop);
  assign w_rd    = r_mem[r_rp[AW-1:0]];

  always_comb begin
    w_last_idx = 3'd3;
    case (w_rd[7:6])
      2'd0:    w_last_idx = 3'd1;
      2'd2:    w_last_idx = 3'd5;
      default: w_last_idx = 3'd3;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= {r_s1_mode, w_word};
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      overflow <= 1'b0;
    end else if (cal_start) begin
      r_wp     <= '0;
      r_rp     <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (r_s1_vld && w_full && !w_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      sym_start  <= 1'b0;
      r_sh       <= '0;
      r_left     <= '0;
    end else if (cal_start || !en) begin
      data_valid <= 1'b0;
      sym_start  <= 1'b0;
      if (cal_start) r_left <= '0;
    end else if (r_left != 3'd0) begin
      data_out   <= r_sh[0];
      r_sh       <= {1'b0, r_sh[4:1]};
      r_left     <= r_left - 3'd1;
      data_valid <= 1'b1;
      sym_start  <= 1'b0;
    end else if (!w_empty) begin
      data_out   <= w_rd[0];
      r_sh       <= w_rd[5:1];
      r_left     <= w_last_idx;
      data_valid <= 1'b1;
      sym_start  <= 1'b1;
    end else begin
      data_valid <= 1'b0;
      sym_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qam_demapper_serial.sv
// Scoreboard bench for qam_demapper_serial: expected serial bits are queued as symbols are driven.
module tb_qam_demapper_serial;

  logic              dclk = 1'b0;
  logic              rst;
  logic signed [7:0] i_in, q_in;
  logic              sym_valid, cal_start, en;
  logic [1:0]        mode;
  logic              data_out, data_valid, sym_start, cal_busy, overflow;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_words = 0;
  int         off_i = 0;
  int         off_q = 0;
  logic [1:0] exp_q[$];

  int tv[10][3] = '{'{32, -32, 2}, '{33, -33, 2}, '{64, -64, 2}, '{65, -65, 2}, '{96, -96, 2},
                    '{97, -97, 2}, '{0, 0, 2}, '{64, -64, 1}, '{65, -65, 1}, '{-1, 1, 3}};

  always #5 dclk = ~dclk;

  qam_demapper_serial #(.IN_W(8), .FIFO_DEPTH(8), .CAL_LOG2(4)) dut (
    .dclk(dclk), .rst(rst), .i_in(i_in), .q_in(q_in), .sym_valid(sym_valid), .mode(mode),
    .cal_start(cal_start), .en(en), .data_out(data_out), .data_valid(data_valid),
    .sym_start(sym_start), .cal_busy(cal_busy), .overflow(overflow)
  );

  function automatic int sat8(int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Number of thresholds crossed away from zero (0..3).
  function automatic int level(int c);
    int l;
    l = 0;
    if (c > 0) begin
      if (c > 32) l++;
      if (c > 64) l++;
      if (c > 96) l++;
    end else begin
      if (c <= -32) l++;
      if (c <= -64) l++;
      if (c <= -96) l++;
    end
    return l;
  endfunction

  function automatic logic [1:0] gray_inv(int a);
    case (a)
      0: return 2'b11;
      1: return 2'b10;
      2: return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int nbits(int m);
    if (m == 0) return 2;
    if (m == 2) return 6;
    return 4;
  endfunction

  function automatic logic [5:0] model_word(int i, int q, int m);
    int ci, cq;
    logic ip, qn, ai16, aq16;
    ci = sat8(i - off_i);
    cq = sat8(q - off_q);
    ip = (ci > 0);
    qn = !(cq > 0);
    ai16 = (level(ci) < 2);
    aq16 = (level(cq) < 2);
    if (m == 0) return {4'b0000, ip, qn};
    if (m == 2) return {ip, gray_inv(level(ci)), qn, gray_inv(level(cq))};
    return {2'b00, ip, ai16, qn, aq16};
  endfunction

  task automatic push_exp(input logic [5:0] w, input int b);
    for (int k = 0; k < b; k++) exp_q.push_back({w[k], 1'(k == 0)});
  endtask

  task automatic send(input int i, input int q, input int m, input bit expect_out);
    i_in = 8'(i);
    q_in = 8'(q);
    mode = 2'(m);
    sym_valid = 1'b1;
    if (expect_out) push_exp(model_word(i, q, m), nbits(m));
    @(negedge dclk);
    sym_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge dclk);
      c++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d bits still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge dclk);
  endtask

  task automatic monitor();
    logic [1:0] e;
    forever begin
      @(negedge dclk);
      if (rst && data_valid) begin
        n_vec++;
        if (sym_start) n_words++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_bit: data_valid=1 data_out=%0b, required no output", data_out);
        end else begin
          e = exp_q.pop_front();
          if ({data_out, sym_start} !== e) begin
            n_err++;
            $display("FAIL serial_bit: bit=%0b sym_start=%0b, required bit=%0b sym_start=%0b",
                     data_out, sym_start, e[1], e[0]);
          end
        end
      end
    end
  endtask

  // Runs n consecutive calibration samples after a cal_start pulse; returns with cal finished if n==16.
  task automatic cal_run(input int vi, input int vq, input int n, input bit pulse);
    if (pulse) begin
      cal_start = 1'b1;
      @(negedge dclk);
      cal_start = 1'b0;
      n_vec++;
      if (cal_busy !== 1'b1) begin
        n_err++;
        $display("FAIL cal_busy_rise: got %0b, required 1", cal_busy);
      end
    end
    for (int k = 0; k < n; k++) begin
      i_in = 8'(vi);
      q_in = 8'(vq);
      sym_valid = 1'b1;
      @(negedge dclk);
      if (k == 14) begin
        n_vec++;
        if (cal_busy !== 1'b1) begin
          n_err++;
          $display("FAIL cal_busy_hold: got %0b, required 1", cal_busy);
        end
      end
      if (k == 15) begin
        n_vec++;
        if (cal_busy !== 1'b0) begin
          n_err++;
          $display("FAIL cal_busy_fall: got %0b, required 0", cal_busy);
        end
      end
    end
    sym_valid = 1'b0;
    if (n == 16) begin
      off_i = (16 * vi) >>> 4;
      off_q = (16 * vq) >>> 4;
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec += 5;
    if (data_out !== 1'b0)   begin n_err++; $display("FAIL rst_data_out: got %0b, required 0", data_out); end
    if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_data_valid: got %0b, required 0", data_valid); end
    if (sym_start !== 1'b0)  begin n_err++; $display("FAIL rst_sym_start: got %0b, required 0", sym_start); end
    if (cal_busy !== 1'b0)   begin n_err++; $display("FAIL rst_cal_busy: got %0b, required 0", cal_busy); end
    if (overflow !== 1'b0)   begin n_err++; $display("FAIL rst_overflow: got %0b, required 0", overflow); end
    @(negedge dclk);
    rst = 1'b1;
    repeat (2) @(negedge dclk);
  endtask

  task automatic test_latency_16qam();
    send(100, -100, 1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge dclk);
      n_vec++;
      if (data_valid !== (k == 3) || (k == 3 && sym_start !== 1'b1)) begin
        n_err++;
        $display("FAIL latency_edge%0d: data_valid=%0b sym_start=%0b, required data_valid=%0b",
                 k, data_valid, sym_start, (k == 3));
      end
    end
    drain(20);
  endtask

  task automatic test_64qam_and_boundaries();
    send(50, -100, 2, 1'b1);
    drain(20);
    for (int t = 0; t < 10; t++) begin
      send(tv[t][0], tv[t][1], tv[t][2], 1'b1);
      repeat (4) @(negedge dclk);
    end
    drain(200);
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL boundary_overflow: got %0b, required 0", overflow); end
  endtask

  task automatic test_back_to_back();
    int run, w;
    run = 0;
    w = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send(10 * k - 35, 40 - 11 * k, 0, 1'b1);
          @(negedge dclk);
        end
      end
      begin
        while (!data_valid && w < 20) begin @(negedge dclk); w++; end
        while (data_valid && run < 40) begin run++; @(negedge dclk); end
      end
    join
    n_vec += 2;
    if (run != 16) begin n_err++; $display("FAIL b2b_stream: %0d contiguous bits, required 16", run); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow: got %0b, required 0", overflow); end
    drain(40);
  endtask

  task automatic test_calibration();
    cal_run(20, -10, 16, 1'b1);
    send(20, -10, 1, 1'b1);
    drain(20);
    cal_run(-100, 0, 16, 1'b1);
    send(100, 0, 1, 1'b1);
    send(100, 0, 2, 1'b1);
    drain(40);
    cal_run(50, 50, 5, 1'b1);
    cal_run(0, 0, 16, 1'b1);
    send(40, -40, 2, 1'b1);
    send(-100, 100, 2, 1'b1);
    drain(40);
  endtask

  task automatic test_overflow();
    int w0;
    en = 1'b0;
    for (int k = 0; k < 9; k++) send(60 + 5 * k, -70 + 9 * k, 1, k < 8);
    repeat (3) @(negedge dclk);
    n_vec += 2;
    if (overflow !== 1'b1)   begin n_err++; $display("FAIL ovf_set: got %0b, required 1", overflow); end
    if (data_valid !== 1'b0) begin n_err++; $display("FAIL ovf_paused: data_valid=%0b, required 0", data_valid); end
    w0 = n_words;
    en = 1'b1;
    repeat (10) @(negedge dclk);
    en = 1'b0;
    repeat (2) begin
      @(negedge dclk);
      n_vec++;
      if (data_valid !== 1'b0) begin n_err++; $display("FAIL en_pause: data_valid=%0b, required 0", data_valid); end
    end
    en = 1'b1;
    drain(100);
    n_vec += 2;
    if (n_words - w0 != 8) begin n_err++; $display("FAIL ovf_words: %0d words out, required 8", n_words - w0); end
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b, required 1", overflow); end
    cal_start = 1'b1;
    @(negedge dclk);
    cal_start = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %0b, required 0", overflow); end
    cal_run(0, 0, 16, 1'b0);
  endtask

  task automatic test_reset_midword();
    int seen;
    seen = 0;
    send(50, -100, 2, 1'b1);
    repeat (5) @(negedge dclk);
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if ({data_out, data_valid, sym_start, cal_busy, overflow} !== 5'b0) begin
      n_err++;
      $display("FAIL async_reset: outputs=%b, required 00000",
               {data_out, data_valid, sym_start, cal_busy, overflow});
    end
    exp_q.delete();
    off_i = 0;
    off_q = 0;
    @(negedge dclk);
    rst = 1'b1;
    repeat (12) begin
      @(negedge dclk);
      if (data_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL post_reset_empty: %0d valid bits, required 0", seen); end
    send(-20, 20, 0, 1'b1);
    drain(20);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    i_in = '0;
    q_in = '0;
    sym_valid = 1'b0;
    mode = 2'd0;
    cal_start = 1'b0;
    en = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_latency_16qam();
    test_64qam_and_boundaries();
    test_back_to_back();
    test_calibration();
    test_overflow();
    test_reset_midword();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
